// File: rtl/barcode_rx_pkg.sv
// Shared types and constants for the barcode station reader.
package barcode_pkg;

    typedef enum logic [1:0] {IDLE, MEASURE, WAIT_FALL, SAMPLE} bc_state_t;

    localparam int BITS = 8;
    localparam logic [1:0] VALID_TAG = 2'b00;

    // Station IDs are tagged in their two MSBs; anything else is noise.
    function automatic logic isValid(input logic [BITS-1:0] word);
        return word[BITS-1 -: 2] == VALID_TAG;
    endfunction

endpackage

// File: rtl/barcode_rx_if.sv
// Barcode line and ID handshake between the reader and the command controller.
interface barcode_rx_if;
    import barcode_pkg::*;

    logic            BC;
    logic            clr_ID_vld;
    logic [BITS-1:0] ID;
    logic            ID_vld;

    modport master (output BC, output clr_ID_vld, input ID, input ID_vld);
    modport slave  (input BC, input clr_ID_vld, output ID, output ID_vld);

endinterface

// File: rtl/barcode_rx_edge_det.sv
// Two-flop synchronizer for the raw barcode line plus an edge-detect flop.
module bc_edge_det
    import barcode_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic bc_i,
    output logic bcS_o,
    output logic fall_o,
    output logic rise_o
);

    logic bcMeta_q;
    logic bcSync_q;
    logic bcDly_q;

    // Reset to 1 because the line idles high; no spurious edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcMeta_q <= 1'b1;
            bcSync_q <= 1'b1;
            bcDly_q  <= 1'b1;
        end else begin
            bcMeta_q <= bc_i;
            bcSync_q <= bcMeta_q;
            bcDly_q  <= bcSync_q;
        end
    end

    assign bcS_o  = bcSync_q;
    assign fall_o = bcDly_q & ~bcSync_q;
    assign rise_o = ~bcDly_q & bcSync_q;

endmodule

// File: rtl/barcode_rx.sv
// Barcode reader: learns the bit period from the start pulse, samples eight
// data bits MSB-first and hands valid station IDs to the command controller.
module barcode_rx
    import barcode_pkg::*;
#(
    parameter int unsigned          CNT_W   = 22,
    parameter logic [CNT_W-1:0]     TIMEOUT = {CNT_W{1'b1}}
) (
    input  logic        clk,
    input  logic        rst_n,
    barcode_rx_if.slave bus
);

    localparam int               CW       = $clog2(BITS);
    localparam logic [CW-1:0]    LAST_BIT = CW'(BITS - 1);

    bc_state_t         state_q, state_d;
    logic [CNT_W-1:0]  tmr_q;
    logic [CNT_W-1:0]  period_q;
    logic [BITS-1:0]   shift_q;
    logic [CW-1:0]     bitCnt_q;
    logic [BITS-1:0]   id_q;
    logic              idVld_q;

    logic              bcS, fall, rise;
    logic              sampleHit, timeoutHit, lastBit;
    logic              tmrClr, tmrInc, periodLd, shiftEn, wordDone;
    logic [BITS-1:0]   shiftNext;

    bc_edge_det uEdge (
        .clk    (clk),
        .rst_n  (rst_n),
        .bc_i   (bus.BC),
        .bcS_o  (bcS),
        .fall_o (fall),
        .rise_o (rise)
    );

    assign sampleHit  = (state_q == SAMPLE) && (tmr_q == period_q);
    assign timeoutHit = (state_q == WAIT_FALL) && (tmr_q == TIMEOUT);
    assign lastBit    = (bitCnt_q == LAST_BIT);
    assign shiftNext  = {shift_q[BITS-2:0], bcS};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (fall) state_d = MEASURE;
            MEASURE:   if (rise) state_d = WAIT_FALL;
            WAIT_FALL: begin
                if (fall)            state_d = SAMPLE;
                else if (timeoutHit) state_d = IDLE;
            end
            SAMPLE:    if (sampleHit) state_d = lastBit ? IDLE : WAIT_FALL;
            default:   state_d = IDLE;
        endcase
    end

    // Edges during SAMPLE are deliberately ignored until the sample point.
    always_comb begin
        tmrClr   = ((state_q == IDLE) || (state_q == WAIT_FALL)) && fall;
        tmrInc   = (state_q != IDLE) && !((state_q == MEASURE) && (&tmr_q));
        periodLd = (state_q == MEASURE) && rise;
        shiftEn  = sampleHit;
        wordDone = sampleHit && lastBit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q    <= '0;
            period_q <= '0;
            shift_q  <= '0;
            bitCnt_q <= '0;
        end else begin
            if (tmrClr)      tmr_q <= '0;
            else if (tmrInc) tmr_q <= tmr_q + 1'b1;
            if (periodLd) begin
                period_q <= tmr_q;
                bitCnt_q <= '0;
            end else if (shiftEn) begin
                bitCnt_q <= bitCnt_q + 1'b1;
            end
            if (shiftEn) shift_q <= shiftNext;
        end
    end

    // An accepted word beats a simultaneous clear from the controller.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q    <= '0;
            idVld_q <= 1'b0;
        end else if (wordDone && isValid(shiftNext)) begin
            id_q    <= shiftNext;
            idVld_q <= 1'b1;
        end else if (bus.clr_ID_vld) begin
            idVld_q <= 1'b0;
        end
    end

    assign bus.ID     = id_q;
    assign bus.ID_vld = idVld_q;

endmodule

// File: tb/tb_barcode_rx.sv
// Self-checking bench for barcode_rx: directed scenarios plus random frames
// compared against a word-level model of the accept/hold/clear rules.
module tb_barcode_rx;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [7:0] expId;
    logic       expVld;

    bit monOn;
    int vldHighCnt;
    int vldLowCnt;
    logic [7:0] idWhileHigh;

    barcode_rx_if bus ();

    barcode_rx #(.CNT_W(22), .TIMEOUT(22'd1000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts how ID_vld behaves cycle by cycle while a scenario is watching.
    always @(negedge clk) begin
        if (monOn) begin
            if (bus.ID_vld === 1'b1) begin
                vldHighCnt++;
                idWhileHigh = bus.ID;
            end else begin
                vldLowCnt++;
            end
        end
    end

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic startMon();
        vldHighCnt = 0;
        vldLowCnt  = 0;
        monOn      = 1'b1;
    endtask

    // Word-level reference: tagged words are taken, others leave state alone.
    task automatic modelFrame(input logic [7:0] w);
        if (w < 8'h40) begin
            expId  = w;
            expVld = 1'b1;
        end
    endtask

    task automatic sendStart(input int p);
        bus.BC = 1'b0;
        idleCycles(p);
        bus.BC = 1'b1;
        idleCycles(2 * p);
    endtask

    task automatic sendBits(input logic [7:0] w, input int p, input int nBits);
        int lowLen;
        for (int i = 0; i < nBits; i++) begin
            lowLen = w[7 - i] ? (p / 2) : (3 * p / 2);
            bus.BC = 1'b0;
            idleCycles(lowLen);
            bus.BC = 1'b1;
            idleCycles(3 * p - lowLen);
        end
    endtask

    task automatic sendFrame(input logic [7:0] w, input int p);
        sendStart(p);
        sendBits(w, p, 8);
        idleCycles(10);
    endtask

    task automatic pulseClr();
        bus.clr_ID_vld = 1'b1;
        idleCycles(1);
        bus.clr_ID_vld = 1'b0;
        expVld = 1'b0;
    endtask

    task automatic test_reset();
        bus.BC = 1'b1;
        bus.clr_ID_vld = 1'b0;
        rst_n = 1'b0;
        idleCycles(3);
        checks++;
        if (bus.ID !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_id: got %h expected 00", bus.ID);
        end
        checks++;
        if (bus.ID_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_vld: got %b expected 0", bus.ID_vld);
        end
        rst_n = 1'b1;
        idleCycles(5);
        expId  = 8'h00;
        expVld = 1'b0;
    endtask

    task automatic test_valid_frame();
        startMon();
        sendFrame(8'h25, 100);
        monOn = 1'b0;
        modelFrame(8'h25);
        checks++;
        if (bus.ID !== expId || bus.ID_vld !== expVld) begin
            errors++;
            $display("[TB] FAIL valid_25: got %h/%b expected %h/%b", bus.ID, bus.ID_vld, expId, expVld);
        end
        checks++;
        if (vldLowCnt == 0 || vldHighCnt == 0) begin
            errors++;
            $display("[TB] FAIL valid_25_rise: low %0d high %0d cycles, both must be nonzero", vldLowCnt, vldHighCnt);
        end
    endtask

    task automatic test_invalid_frame();
        pulseClr();
        checks++;
        if (bus.ID_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clr_pulse: got %b expected 0", bus.ID_vld);
        end
        sendFrame(8'hC5, 100);
        modelFrame(8'hC5);
        checks++;
        if (bus.ID !== expId || bus.ID_vld !== expVld) begin
            errors++;
            $display("[TB] FAIL invalid_C5: got %h/%b expected %h/%b", bus.ID, bus.ID_vld, expId, expVld);
        end
    endtask

    task automatic test_back_to_back();
        sendFrame(8'h25, 100);
        modelFrame(8'h25);
        idleCycles(50);
        startMon();
        sendFrame(8'h12, 100);
        monOn = 1'b0;
        modelFrame(8'h12);
        checks++;
        if (vldLowCnt != 0) begin
            errors++;
            $display("[TB] FAIL hold_vld: ID_vld low for %0d cycles, required 0", vldLowCnt);
        end
        checks++;
        if (bus.ID !== expId || bus.ID_vld !== expVld) begin
            errors++;
            $display("[TB] FAIL overwrite_12: got %h/%b expected %h/%b", bus.ID, bus.ID_vld, expId, expVld);
        end
        pulseClr();
        checks++;
        if (bus.ID_vld !== 1'b0 || bus.ID !== expId) begin
            errors++;
            $display("[TB] FAIL clr_after_12: got %h/%b expected %h/0", bus.ID, bus.ID_vld, expId);
        end
    endtask

    // Clear is held for the whole frame, so it is also high in the accept
    // cycle: ID_vld must appear for exactly one cycle carrying the new word.
    task automatic test_clr_collision();
        bus.clr_ID_vld = 1'b1;
        startMon();
        sendFrame(8'h3F, 100);
        monOn = 1'b0;
        bus.clr_ID_vld = 1'b0;
        expId  = 8'h3F;
        expVld = 1'b0;
        checks++;
        if (vldHighCnt != 1) begin
            errors++;
            $display("[TB] FAIL set_beats_clr: ID_vld high %0d cycles, required 1", vldHighCnt);
        end
        checks++;
        if (idWhileHigh !== 8'h3F || bus.ID !== expId) begin
            errors++;
            $display("[TB] FAIL collision_id: got %h/%h expected 3F", idWhileHigh, bus.ID);
        end
    endtask

    task automatic test_timeout();
        sendStart(100);
        sendBits(8'hA5, 100, 3);
        idleCycles(1200);
        checks++;
        if (bus.ID_vld !== 1'b0 || bus.ID !== expId) begin
            errors++;
            $display("[TB] FAIL timeout_abort: got %h/%b expected %h/0", bus.ID, bus.ID_vld, expId);
        end
        sendFrame(8'h07, 100);
        modelFrame(8'h07);
        checks++;
        if (bus.ID !== expId || bus.ID_vld !== expVld) begin
            errors++;
            $display("[TB] FAIL after_timeout_07: got %h/%b expected %h/%b", bus.ID, bus.ID_vld, expId, expVld);
        end
    endtask

    task automatic test_reset_mid_frame();
        sendStart(100);
        sendBits(8'h25, 100, 4);
        rst_n = 1'b0;
        #1;
        expId  = 8'h00;
        expVld = 1'b0;
        checks++;
        if (bus.ID !== expId || bus.ID_vld !== expVld) begin
            errors++;
            $display("[TB] FAIL mid_reset: got %h/%b expected 00/0", bus.ID, bus.ID_vld);
        end
        idleCycles(3);
        rst_n = 1'b1;
        idleCycles(5);
        sendFrame(8'h21, 100);
        modelFrame(8'h21);
        checks++;
        if (bus.ID !== expId || bus.ID_vld !== expVld) begin
            errors++;
            $display("[TB] FAIL after_reset_21: got %h/%b expected %h/%b", bus.ID, bus.ID_vld, expId, expVld);
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] w;
        int p;
        for (int n = 0; n < 8; n++) begin
            p = $urandom_range(40, 120);
            w = 8'($urandom);
            if ($urandom_range(0, 1) == 1) w[7:6] = 2'b00;
            if ($urandom_range(0, 2) == 0) begin
                pulseClr();
                checks++;
                if (bus.ID_vld !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL rand_clr_%0d: got %b expected 0", n, bus.ID_vld);
                end
            end
            sendFrame(w, p);
            modelFrame(w);
            checks++;
            if (bus.ID !== expId || bus.ID_vld !== expVld) begin
                errors++;
                $display("[TB] FAIL rand_frame_%0d (w=%h p=%0d): got %h/%b expected %h/%b",
                         n, w, p, bus.ID, bus.ID_vld, expId, expVld);
            end
            idleCycles($urandom_range(5, 40));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        monOn  = 1'b0;
        vldHighCnt = 0;
        vldLowCnt  = 0;
        idWhileHigh = 8'h00;
        test_reset();
        test_valid_frame();
        test_invalid_frame();
        test_back_to_back();
        test_clr_collision();
        test_timeout();
        test_reset_mid_frame();
        test_random_frames();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
